// File: rtl/elevator_controller_if.sv
// Signal bundle between the elevator scheduler and its environment:
// time-base strobe, call inputs and emergency stop in; request mask,
// car position, display state and SCAN direction out.
interface elevator_controller_if #(
  parameter int FLOORS = 16
) ();
  logic              tick;
  logic [FLOORS-1:0] call_req;
  logic              emergency_stop;
  logic [15:0]       destination;
  logic [3:0]        current_floor;
  logic [1:0]        sim_state;
  logic              dir_up;

  // Environment side: drives time base and calls, observes the car.
  modport master (
    output tick, call_req, emergency_stop,
    input  destination, current_floor, sim_state, dir_up
  );

  // Controller side.
  modport slave (
    input  tick, call_req, emergency_stop,
    output destination, current_floor, sim_state, dir_up
  );
endinterface

// File: rtl/elevator_controller.sv
// Elevator car scheduler: latches floor calls, runs a SCAN (keep-direction)
// policy, steps the car one floor per MOVE_TICKS strobes and holds the door
// open for DOOR_TICKS strobes. All outputs come straight from registers.
module elevator_controller #(
  parameter int FLOORS     = 16,
  parameter int MOVE_TICKS = 8,
  parameter int DOOR_TICKS = 4
) (
  input logic                  clk,
  input logic                  rst,
  elevator_controller_if.slave bus
);

  localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    TOP_FLOOR = 4'(FLOORS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_DOOR = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   pending_q, pending_d;
  logic [3:0]    floor_q, floor_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_up_q, dir_up_d;

  logic [15:0]   call_ext_s;
  logic [15:0]   call_s;
  logic [15:0]   clr_s;
  logic [3:0]    next_up_s;
  logic [3:0]    next_dn_s;
  logic          above_s;
  logic          below_s;

  // Any request strictly above floor f.
  function automatic logic any_above(input logic [15:0] p, input logic [3:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r = r | (p[i] & (i > int'(f)));
    end
    return r;
  endfunction

  // Any request strictly below floor f.
  function automatic logic any_below(input logic [15:0] p, input logic [3:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r = r | (p[i] & (i < int'(f)));
    end
    return r;
  endfunction

  // Zero-extend the call vector to 16 bits so unused floors stay cleared.
  for (genvar g = 0; g < 16; g++) begin : g_call_ext
    if (g < FLOORS) begin : g_used
      assign call_ext_s[g] = bus.call_req[g];
    end else begin : g_unused
      assign call_ext_s[g] = 1'b0;
    end
  end

  assign next_up_s = floor_q + 4'd1;
  assign next_dn_s = floor_q - 4'd1;
  assign above_s   = any_above(pending_q, floor_q);
  assign below_s   = any_below(pending_q, floor_q);

  // Next-state computation for the SCAN state machine, counter and position.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    call_s   = call_ext_s;
    clr_s    = 16'h0000;
    // A call for the floor whose door is open is absorbed rather than latched.
    if (state_q == S_DOOR) begin
      call_s[floor_q] = 1'b0;
    end else begin
      call_s = call_ext_s;
    end
    if (!bus.emergency_stop) begin
      case (state_q)
        S_IDLE: begin
          if (pending_q[floor_q]) begin
            state_d         = S_DOOR;
            clr_s[floor_q]  = 1'b1;
            cnt_d           = CNT_ZERO;
          end else if (above_s && (dir_up_q || !below_s)) begin
            state_d  = S_UP;
            dir_up_d = 1'b1;
            cnt_d    = CNT_ZERO;
          end else if (below_s) begin
            state_d  = S_DOWN;
            dir_up_d = 1'b0;
            cnt_d    = CNT_ZERO;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_UP: begin
          if (bus.tick) begin
            if (cnt_q == MOVE_LAST) begin
              cnt_d = CNT_ZERO;
              if (floor_q == TOP_FLOOR) begin
                state_d = S_IDLE;
              end else begin
                floor_d = next_up_s;
                if (pending_q[next_up_s]) begin
                  state_d          = S_DOOR;
                  clr_s[next_up_s] = 1'b1;
                end else if (any_above(pending_q, next_up_s)) begin
                  state_d = S_UP;
                end else begin
                  state_d = S_IDLE;
                end
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_DOWN: begin
          if (bus.tick) begin
            if (cnt_q == MOVE_LAST) begin
              cnt_d = CNT_ZERO;
              if (floor_q == 4'd0) begin
                state_d = S_IDLE;
              end else begin
                floor_d = next_dn_s;
                if (pending_q[next_dn_s]) begin
                  state_d          = S_DOOR;
                  clr_s[next_dn_s] = 1'b1;
                end else if (any_below(pending_q, next_dn_s)) begin
                  state_d = S_DOWN;
                end else begin
                  state_d = S_IDLE;
                end
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_DOOR: begin
          // A fresh call for this floor restarts the full door-open interval.
          if (call_ext_s[floor_q]) begin
            cnt_d = CNT_ZERO;
          end else if (bus.tick) begin
            if (cnt_q == DOOR_LAST) begin
              state_d = S_IDLE;
              cnt_d   = CNT_ZERO;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // New calls win over clears, except the absorbed door-floor call above.
  assign pending_d = (pending_q & ~clr_s) | call_s;

  // State registers with asynchronous return to floor 0, idle, no requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pending_q <= 16'h0000;
      floor_q   <= 4'd0;
      cnt_q     <= CNT_ZERO;
      dir_up_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      floor_q   <= floor_d;
      cnt_q     <= cnt_d;
      dir_up_q  <= dir_up_d;
    end
  end

  assign bus.destination   = pending_q;
  assign bus.current_floor = floor_q;
  assign bus.sim_state     = state_q;
  assign bus.dir_up        = dir_up_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller (16 floors, 8 ticks per floor,
// 4 ticks door). Ticks are issued every 4 clocks; outputs are sampled 1 ns
// after the rising edge.
module tb_elevator_controller;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  elevator_controller_if #(.FLOORS(16)) bus ();

  elevator_controller #(
    .FLOORS    (16),
    .MOVE_TICKS(8),
    .DOOR_TICKS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic car(input string tag, input logic [3:0] fl, input logic [1:0] st,
                     input logic [15:0] dest);
    check({tag, "_floor"}, 32'(bus.current_floor), 32'(fl));
    check({tag, "_state"}, 32'(bus.sim_state), 32'(st));
    check({tag, "_dest"},  32'(bus.destination), 32'(dest));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n tick strobes; each preceded by 3 quiet cycles, sampled right after the tick edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) step();
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
    end
  endtask

  // The car must never move up from the top floor or down from floor 0.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.sim_state == 2'b01) begin
      checks++;
      assert (bus.current_floor !== 4'd15) else begin
        errors++;
        $error("FAIL up_at_top observed floor 0x%0h", bus.current_floor);
      end
    end
    if (rst === 1'b1 && bus.sim_state == 2'b10) begin
      checks++;
      assert (bus.current_floor !== 4'd0) else begin
        errors++;
        $error("FAIL down_at_bottom observed floor 0x%0h", bus.current_floor);
      end
    end
  end

  initial begin
    rst                = 1'b0;
    bus.tick           = 1'b0;
    bus.call_req       = 16'h0000;
    bus.emergency_stop = 1'b0;
    #12;
    car("reset", 4'd0, 2'b00, 16'h0000);
    check("reset_dir", 32'(bus.dir_up), 32'd1);
    step();
    rst = 1'b1;

    // Single call to floor 3, travel 0 -> 3, door cycle.
    bus.call_req = 16'h0008;
    step();
    car("s1_latch", 4'd0, 2'b00, 16'h0008);
    bus.call_req = 16'h0000;
    step();
    car("s1_depart", 4'd0, 2'b01, 16'h0008);
    check("s1_dir", 32'(bus.dir_up), 32'd1);
    ticks(8);
    car("s1_f1", 4'd1, 2'b01, 16'h0008);
    ticks(8);
    car("s1_f2", 4'd2, 2'b01, 16'h0008);
    ticks(7);
    car("s1_f2_hold", 4'd2, 2'b01, 16'h0008);
    ticks(1);
    car("s1_arrive", 4'd3, 2'b11, 16'h0000);
    ticks(3);
    car("s1_door", 4'd3, 2'b11, 16'h0000);
    ticks(1);
    car("s1_close", 4'd3, 2'b00, 16'h0000);

    // Door reopen: call for the open floor restarts the door interval.
    bus.call_req = 16'h0008;
    step();
    car("s3_latch", 4'd3, 2'b00, 16'h0008);
    bus.call_req = 16'h0000;
    step();
    car("s3_open", 4'd3, 2'b11, 16'h0000);
    ticks(2);
    bus.call_req = 16'h0008;
    step();
    bus.call_req = 16'h0000;
    car("s3_reload", 4'd3, 2'b11, 16'h0000);
    ticks(3);
    car("s3_still_open", 4'd3, 2'b11, 16'h0000);
    ticks(1);
    car("s3_close", 4'd3, 2'b00, 16'h0000);

    // SCAN: serve 7 and 8 going up, then reverse for 2.
    bus.call_req = 16'h0184;
    step();
    car("s2_latch", 4'd3, 2'b00, 16'h0184);
    bus.call_req = 16'h0000;
    step();
    car("s2_depart", 4'd3, 2'b01, 16'h0184);
    ticks(16);
    car("s2_f5", 4'd5, 2'b01, 16'h0184);
    ticks(16);
    car("s2_f7", 4'd7, 2'b11, 16'h0104);
    ticks(4);
    car("s2_f7_close", 4'd7, 2'b00, 16'h0104);
    step();
    car("s2_f7_up", 4'd7, 2'b01, 16'h0104);
    ticks(8);
    car("s2_f8", 4'd8, 2'b11, 16'h0004);
    ticks(4);
    car("s2_f8_close", 4'd8, 2'b00, 16'h0004);
    step();
    car("s2_reverse", 4'd8, 2'b10, 16'h0004);
    check("s2_dir_down", 32'(bus.dir_up), 32'd0);
    ticks(24);
    car("s2_f5_down", 4'd5, 2'b10, 16'h0004);
    ticks(24);
    car("s2_f2", 4'd2, 2'b11, 16'h0000);
    ticks(4);
    car("s2_f2_close", 4'd2, 2'b00, 16'h0000);

    // Emergency stop mid-move, calls still latched, exact resume.
    bus.call_req = 16'h0040;
    step();
    car("s4_latch", 4'd2, 2'b00, 16'h0040);
    bus.call_req = 16'h0000;
    step();
    car("s4_depart", 4'd2, 2'b01, 16'h0040);
    check("s4_dir_up", 32'(bus.dir_up), 32'd1);
    ticks(3);
    bus.emergency_stop = 1'b1;
    ticks(10);
    bus.call_req = 16'h8000;
    step();
    bus.call_req = 16'h0000;
    car("s4_estop_call", 4'd2, 2'b01, 16'h8040);
    ticks(10);
    car("s4_frozen", 4'd2, 2'b01, 16'h8040);
    bus.emergency_stop = 1'b0;
    ticks(4);
    car("s4_resume_hold", 4'd2, 2'b01, 16'h8040);
    ticks(1);
    car("s4_f3", 4'd3, 2'b01, 16'h8040);
    ticks(24);
    car("s4_f6", 4'd6, 2'b11, 16'h8000);
    ticks(4);
    car("s4_f6_close", 4'd6, 2'b00, 16'h8000);
    step();
    car("s4_f6_up", 4'd6, 2'b01, 16'h8000);
    ticks(3);

    // Asynchronous reset mid-move at floor 6, away from any clock edge.
    #2;
    rst = 1'b0;
    #1;
    car("s6_async", 4'd0, 2'b00, 16'h0000);
    check("s6_dir", 32'(bus.dir_up), 32'd1);
    step();
    rst = 1'b1;
    step();
    car("s6_after", 4'd0, 2'b00, 16'h0000);

    // Call at the current floor while idle: door opens, no movement.
    bus.call_req = 16'h0001;
    step();
    car("s5_latch", 4'd0, 2'b00, 16'h0001);
    bus.call_req = 16'h0000;
    step();
    car("s5_open", 4'd0, 2'b11, 16'h0000);
    ticks(4);
    car("s5_close", 4'd0, 2'b00, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Scheduling and motion state machine for the elevator car; directly upstream of vgaController.
- Latches floor-call requests and runs a SCAN (keep-direction) policy.
- Steps the car floor by floor on a slow tick, opens and closes the door, and exports:
  - the pending-request mask on `destination`
  - the 2-bit `sim_state` consumed by the display.

Parameters:
- FLOORS, 16, number of floors; floors are 0..FLOORS-1; must be 2..16.
- MOVE_TICKS, 8, tick strobes needed to travel one floor; must be ≥1.
- DOOR_TICKS, 4, tick strobes the door stays open; must be ≥1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle time-base strobe (from clkDivider)
- call_req  input  FLOORS  call pulses; bit i requests floor i; any width of pulse accepted
- emergency_stop  input  1  level; freezes motion and timers while high
- destination  output  16  pending-request mask, zero-extended from FLOORS bits
- current_floor  output  4  floor the car is at or last passed
- sim_state  output  2  00 IDLE, 01 MOVE_UP, 10 MOVE_DOWN, 11 DOOR_OPEN
- dir_up  output  1  SCAN preference: 1 = up, 0 = down

Behaviour:
- Reset, asynchronous on rst=0:
  - pending=0, current_floor=0, sim_state=IDLE, dir_up=1, tick counter=0.
  - All outputs are registered.
- Request latch:
  - Every cycle, pending |= call_req.
  - A call appears on `destination` one cycle after it is sampled.
  - Exception: while in DOOR_OPEN, a call for current_floor is not latched. Instead it reloads the door counter (door stays open a full DOOR_TICKS from that point).
- Decisions use only the registered pending. "above" = any pending bit > current_floor; "below" = any pending bit < current_floor.
- IDLE, evaluated every cycle, in priority order:
  - pending[current_floor] set → DOOR_OPEN; clear that bit; counter=0.
  - else above and (dir_up or not below) → MOVE_UP; dir_up=1; counter=0.
  - else below → MOVE_DOWN; dir_up=0; counter=0.
  - else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - Each tick increments the counter.
  - On the tick where counter==MOVE_TICKS-1: current_floor ±1, counter=0, and in that same edge:
    - new floor pending → DOOR_OPEN and clear its bit;
    - else pending further in the same direction → remain in the move state;
    - else → IDLE.
  - Without a tick, all of this is held.
- DOOR_OPEN:
  - Each tick increments the counter.
  - On the tick where counter==DOOR_TICKS-1 → IDLE, counter=0.
- Timing:
  - Latency from a call at floor f≠current (car idle) to sim_state leaving IDLE: 2 clk edges.
  - Arrival one floor away takes MOVE_TICKS ticks after the state change.
- Boundaries:
  - Floor FLOORS-1 never moves up and floor 0 never moves down; this is guaranteed by the above/below logic and additionally asserted in the bench.
  - current_floor never leaves 0..FLOORS-1.
  - Unused `destination` bits [15:FLOORS] are always 0.
- emergency_stop=1:
  - State, counter and current_floor are frozen.
  - Ticks are ignored.
  - IDLE does not depart or open the door.
  - Requests are still latched.
  - On release, the block resumes exactly where it was frozen.
- Simultaneous events:
  - A call arriving on the arrival edge for the arrival floor is latched and served in the next IDLE cycle.
  - An arrival edge cannot miss a bit already pending.
  - Calls and a pending clear on the same edge: clear has priority for current_floor only in DOOR_OPEN (see the exception above). Otherwise, set wins over clear for other bits.
- Reset mid-motion: asynchronous return to floor 0, IDLE, with pending cleared.

Test Plan:
- Reset, then pulse call_req=16'h0008 with tick every 4 cycles and MOVE_TICKS=8:
  - destination=0x0008 next cycle; sim_state=01 two edges after the call.
  - current_floor steps 1, 2, 3, one step every 8 ticks.
  - At floor 3: sim_state=11 and destination=0.
  - After 4 ticks: sim_state=00.
- Car at floor 5 moving up with calls 0x0180 (floors 7, 8) and 0x0004 (floor 2) → serves 7, then 8, then reverses (dir_up=0, sim_state=10) and serves 2.
- In DOOR_OPEN at floor 3, call 0x0008 after 2 ticks → bit not set; door stays open 4 further ticks (6 in total).
- emergency_stop high for 20 ticks mid-move → current_floor and sim_state unchanged; new call 0x8000 appears in destination; motion resumes after release.
- Call at current floor 0 while IDLE → DOOR_OPEN in 2 edges; no movement.
- Assert rst low mid-move at floor 6 → outputs immediately 0 / IDLE / dir_up=1 / destination=0 without waiting for a clock edge.
